mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 Ports shall be, one per line, name direction width meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction opcode field (bits 31:26), sampled from the instruction register.
- Funct  in  6  R-type function field (bits 5:0).
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake: access completes in the cycle it is high.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 use Funct.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding (debug).
- illegal_op  out  1  one-cycle pulse on undefined opcode.
- retired  out  CNT_W  count of completed instructions.

Function
REQ-003 States and encodings shall be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 shall transition to FETCH.
REQ-004 FETCH shall assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
- IRWrite and PCWrite shall be 1 only in the FETCH cycle where mem_ready=1.
- The block shall stay in FETCH while mem_ready=0.
- It shall go to DECODE when mem_ready=1.
REQ-005 DECODE shall drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on Opcode:
- 0x00 to EXEC.
- 0x23 or 0x2B to MEMADR.
- 0x04 to BRANCH.
- 0x08 to ADDIEX.
- 0x02 to JUMP.
- Any other opcode to FETCH, with illegal_op=1 for that DECODE cycle only.
REQ-006 MEMADR shall drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD if Opcode=0x23, else MEMWR.
REQ-007 MEMRD shall drive MemRead=1, IorD=1.
- It shall hold while mem_ready=0.
- When mem_ready=1 it shall go to MEMWB.
REQ-008 MEMWB shall drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-009 MEMWR shall drive MemWrite=1, IorD=1.
- It shall hold while mem_ready=0.
- When mem_ready=1 it shall go to FETCH.
REQ-010 EXEC shall drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-011 ALUWB shall drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-012 BRANCH shall drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-013 ADDIEX shall drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-014 ADDIWB shall drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-015 JUMP shall drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-016 Any control not listed for a state shall be 0.
REQ-017 Control outputs shall be combinational from the state register and mem_ready; state, retired and illegal_op reflect the registered state.
REQ-018 retired shall increment by 1 on each transition into FETCH from MEMWB, MEMWR (mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP.
- It shall not increment on an illegal-opcode return.
- It shall wrap from all-ones to 0.
REQ-019 Funct shall not affect sequencing; it is consumed only by the ALU control when ALUOp=10.
REQ-020 mem_ready shall be ignored in states other than FETCH, MEMRD and MEMWR.

Reset
REQ-021 When reset=1, the block shall immediately force, independent of clk:
- state=FETCH.
- retired=0, illegal_op=0.
- All control outputs 0, including MemRead, IRWrite and PCWrite.
REQ-022 Reset asserted mid-instruction (e.g. in MEMRD with mem_ready=0) shall abandon the instruction, with no RegWrite, MemWrite or PCWrite.
REQ-023 On the first rising clk after reset deasserts, FETCH shall behave per REQ-004.

Verification
REQ-024 The bench shall cover these directed scenarios:
- R-type: Opcode=0x00, mem_ready=1 → states 0,1,6,7,0; RegWrite=1 and RegDst=1 in state 7; retired 0→1.
- lw with mem_ready low 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4,0; MemRead=1 and IorD=1 throughout state 3; RegWrite=1 and MemtoReg=1 in state 4.
- beq, Zero=1 → BRANCH cycle shows PCWriteCond=1, PCSource=01, ALUOp=01; sw → MEMWR asserts MemWrite for exactly one cycle when mem_ready=1.
- Illegal Opcode=0x3F → illegal_op=1 for one cycle in state 1, next state 0, retired unchanged.
- Reset asserted asynchronously in state 3 → state=0 and all controls 0 before the next clk edge; retired=0.
- CNT_W=4, 16 consecutive j (Opcode=0x02) → retired wraps 15→0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback states, drives datapath controls from the current state, flags
// undefined opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             op_legal;

  // Funct and Zero are datapath concerns (ALU control / branch gating);
  // sequencing deliberately ignores them.
  logic unused_ok;
  assign unused_ok = ^{Funct, Zero};

  assign op_legal = (Opcode == OP_RTYPE) || (Opcode == OP_LW) || (Opcode == OP_SW) ||
                    (Opcode == OP_BEQ) || (Opcode == OP_ADDI) || (Opcode == OP_J);

  // Next-state and retire-count logic; a retire is any completed return to FETCH.
  always_comb begin
    state_d   = FETCH;
    retired_d = retired_q;
    unique case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;  // illegal: no retire
        endcase
      end
      MEMADR: state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  begin
        state_d = mem_ready ? FETCH : MEMWR;
        if (mem_ready) retired_d = retired_q + CNT_W'(1);
      end
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        state_d   = FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = FETCH;
    endcase
  end

  // State and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Datapath controls decoded from state; reset masks them all immediately
  // so an abandoned instruction cannot write anything.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00;
    PCSource = 2'b00;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign retired    = retired_q;
  assign illegal_op = !reset && (state_q == DECODE) && !op_legal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: stimulus pushes the expected
// per-cycle response into a queue, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] Opcode = '0, Funct = '0;
  logic Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
        RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  //                MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  wire [15:0] ctrl_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                        MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  localparam logic [15:0] C_FETCH_RDY = 16'h9410, C_FETCH_WAIT = 16'h1010,
    C_DEC = 16'h0030, C_MEMADR = 16'h0060, C_MEMRD = 16'h3000,
    C_MEMWB = 16'h0280, C_MEMWR = 16'h2800, C_EXEC = 16'h0048,
    C_ALUWB = 16'h0180, C_BRANCH = 16'h4045, C_ADDIEX = 16'h0060,
    C_ADDIWB = 16'h0080, C_JUMP = 16'h8002, C_ZERO = 16'h0000;

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic             ill;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic [CNT_W-1:0] ret_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(ctrl_w), 32'(e.ctrl));
      chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      chk("retired", 32'(retired), 32'(e.ret));
    end
  end

  // One cycle: called at posedge+1, drives inputs, queues the expected response.
  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctrl, input logic ill);
    Opcode = op; mem_ready = mr; Funct = 6'($urandom);
    exp_q.push_back('{st, ctrl, ill, ret_m});
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [5:0] op);
    step(op, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
    step(op, 1'b0, 4'd1, C_DEC, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    // reset held: FETCH state but every control forced low
    exp_q.push_back('{4'd0, C_ZERO, 1'b0, '0}); @(posedge clk); #1;
    exp_q.push_back('{4'd0, C_ZERO, 1'b0, '0}); @(posedge clk); #1;
    reset = 1'b0;

    // R-type: 0,1,6,7,0
    fetch(6'h00);
    step(6'h00, 1'b1, 4'd6, C_EXEC, 1'b0);
    step(6'h00, 1'b1, 4'd7, C_ALUWB, 1'b0);
    ret_m++;

    // lw: fetch waits one cycle, MEMRD waits three
    step(6'h23, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);
    fetch(6'h23);
    step(6'h23, 1'b0, 4'd2, C_MEMADR, 1'b0);
    repeat (3) step(6'h23, 1'b0, 4'd3, C_MEMRD, 1'b0);
    step(6'h23, 1'b1, 4'd3, C_MEMRD, 1'b0);
    step(6'h23, 1'b0, 4'd4, C_MEMWB, 1'b0);
    ret_m++;

    // sw: single MEMWR cycle with mem_ready high
    fetch(6'h2B);
    step(6'h2B, 1'b1, 4'd2, C_MEMADR, 1'b0);
    step(6'h2B, 1'b1, 4'd5, C_MEMWR, 1'b0);
    ret_m++;

    // beq with Zero=1
    Zero = 1'b1;
    fetch(6'h04);
    step(6'h04, 1'b0, 4'd8, C_BRANCH, 1'b0);
    ret_m++;
    Zero = 1'b0;

    // addi
    fetch(6'h08);
    step(6'h08, 1'b1, 4'd9, C_ADDIEX, 1'b0);
    step(6'h08, 1'b1, 4'd10, C_ADDIWB, 1'b0);
    ret_m++;

    // illegal opcode: one-cycle flag in DECODE, back to FETCH, no retire
    step(6'h3F, 1'b1, 4'd0, C_FETCH_RDY, 1'b0);
    step(6'h3F, 1'b1, 4'd1, C_DEC, 1'b1);

    // lw interrupted by async reset while stalled in MEMRD
    fetch(6'h23);
    step(6'h23, 1'b0, 4'd2, C_MEMADR, 1'b0);
    step(6'h23, 1'b0, 4'd3, C_MEMRD, 1'b0);
    reset = 1'b1; ret_m = '0;  // mid-cycle, state is still MEMRD before this
    exp_q.push_back('{4'd0, C_ZERO, 1'b0, '0}); @(posedge clk); #1;
    exp_q.push_back('{4'd0, C_ZERO, 1'b0, '0}); @(posedge clk); #1;
    reset = 1'b0;

    // 16 jumps: counter wraps 15 -> 0
    repeat (16) begin
      fetch(6'h02);
      step(6'h02, 1'b0, 4'd11, C_JUMP, 1'b0);
      ret_m++;
    end
    step(6'h00, 1'b0, 4'd0, C_FETCH_WAIT, 1'b0);

    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
